// File: rtl/accel_apb_cmdfifo.sv
// APB command FIFO: the CPU pushes 32-bit command words over APB and the
// accelerator core drains them through a valid/ready stream.  Status, control,
// flush and a registered low-watermark interrupt are provided.

package accel_apb_cmdfifo_pkg;

  localparam logic [15:0] VENDOR_OPTIMITECH        = 16'h00F1;
  localparam logic [15:0] OPTIMITECH_ACCEL_CMDFIFO = 16'h0092;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] mask;
  } mapinfo_type;

  typedef struct packed {
    logic [15:0] vid;
    logic [15:0] did;
    logic [31:0] addr_start;
    logic [31:0] addr_end;
  } dev_config_type;

  typedef struct packed {
    logic        pselx;
    logic        penable;
    logic [31:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
  } apb_in_type;

  typedef struct packed {
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;
  } apb_out_type;

endpackage

module accel_apb_cmdfifo
  import accel_apb_cmdfifo_pkg::*;
#(
  parameter int          fifo_log2 = 4,
  parameter logic [15:0] did       = OPTIMITECH_ACCEL_CMDFIFO
) (
  input  logic           i_clk,
  input  logic           i_nrst,
  input  mapinfo_type    i_mapinfo,
  output dev_config_type o_cfg,
  input  apb_in_type     i_apbi,
  output apb_out_type    o_apbo,
  output logic           o_cmd_valid,
  output logic [31:0]    o_cmd_data,
  input  logic           i_cmd_ready,
  output logic           o_irq
);

  localparam int DEPTH = 1 << fifo_log2;
  localparam int CW    = fifo_log2 + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Bytes with a cleared strobe bit are stored as zero.
  function automatic logic [31:0] strb_mask(input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) begin
      r[8*b +: 8] = s[b] ? d[8*b +: 8] : 8'h00;
    end
    return r;
  endfunction

  logic [31:0]          mem [DEPTH];
  logic [fifo_log2-1:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [CW-1:0]        count, count_nxt;
  logic [CW-1:0]        thresh, thresh_nxt;
  logic                 en, en_nxt;
  logic                 irq_en, irq_en_nxt;
  logic                 ovf, ovf_nxt;
  logic                 irq_r;
  logic                 pready_r, pslverr_r;
  logic [31:0]          prdata_r;

  logic                 setup;
  logic [9:0]           offs;
  logic                 sel_data, sel_stat, sel_ctrl, sel_thr, sel_bad;
  logic                 full, empty;
  logic                 push_req, push_ok, push_ovf;
  logic                 flush, ovf_clr, ctrl_wr, thr_wr;
  logic                 pop;
  logic [31:0]          rdata_c;
  logic                 slverr_c;
  logic                 unused_bits;

  assign unused_bits = ^{i_apbi.pprot, i_apbi.paddr[31:12], i_apbi.paddr[1:0]};

  assign setup    = i_apbi.pselx & ~i_apbi.penable;
  assign offs     = i_apbi.paddr[11:2];
  assign sel_data = (offs == 10'd0);
  assign sel_stat = (offs == 10'd1);
  assign sel_ctrl = (offs == 10'd2);
  assign sel_thr  = (offs == 10'd3);
  assign sel_bad  = ~(sel_data | sel_stat | sel_ctrl | sel_thr);

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // Fullness is judged on the pre-edge count, a same-edge pop does not make room.
  assign push_req = setup & i_apbi.pwrite & sel_data;
  assign push_ok  = push_req & ~full;
  assign push_ovf = push_req & full;
  assign ctrl_wr  = setup & i_apbi.pwrite & sel_ctrl;
  assign thr_wr   = setup & i_apbi.pwrite & sel_thr;
  assign flush    = ctrl_wr & i_apbi.pwdata[2];
  assign ovf_clr  = ctrl_wr & i_apbi.pwdata[3];

  assign o_cmd_valid = en & ~empty;
  assign o_cmd_data  = mem[rd_ptr];
  // Flush takes precedence over a pop on the same edge.
  assign pop = o_cmd_valid & i_cmd_ready & ~flush;

  // Read mux and error decode for the current setup cycle.
  always_comb begin
    rdata_c  = '0;
    slverr_c = sel_bad | push_ovf;
    if (sel_stat) rdata_c = {16'd0, 8'(count), 5'd0, ovf, full, empty};
    if (sel_ctrl) rdata_c = {30'd0, irq_en, en};
    if (sel_thr)  rdata_c = 32'(thresh);
  end

  // Next-state for pointers, count and control registers.
  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    count_nxt  = count;
    en_nxt     = en;
    irq_en_nxt = irq_en;
    thresh_nxt = thresh;
    ovf_nxt    = ovf;
    if (push_ok) wr_ptr_nxt = wr_ptr + 1'b1;
    if (pop)     rd_ptr_nxt = rd_ptr + 1'b1;
    case ({push_ok, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
    if (ctrl_wr) begin
      en_nxt     = i_apbi.pwdata[0];
      irq_en_nxt = i_apbi.pwdata[1];
    end
    if (flush) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
      count_nxt  = '0;
    end
    if (thr_wr)   thresh_nxt = i_apbi.pwdata[CW-1:0];
    if (push_ovf) ovf_nxt = 1'b1;
    else if (ovf_clr) ovf_nxt = 1'b0;
  end

  // FIFO and control state.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      en     <= 1'b0;
      irq_en <= 1'b0;
      thresh <= '0;
      ovf    <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      count  <= count_nxt;
      en     <= en_nxt;
      irq_en <= irq_en_nxt;
      thresh <= thresh_nxt;
      ovf    <= ovf_nxt;
    end
  end

  // Storage; cleared on reset so the head word reads zero out of reset.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push_ok) begin
      mem[wr_ptr] <= strb_mask(i_apbi.pwdata, i_apbi.pstrb);
    end
  end

  // Registered APB response: committed on the setup edge, dropped after access.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      pready_r  <= 1'b0;
      prdata_r  <= '0;
      pslverr_r <= 1'b0;
    end else begin
      pready_r <= setup;
      if (setup) begin
        prdata_r  <= i_apbi.pwrite ? 32'd0 : rdata_c;
        pslverr_r <= slverr_c;
      end
    end
  end

  // Low-watermark interrupt from next-state values.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) irq_r <= 1'b0;
    else         irq_r <= irq_en_nxt & en_nxt & (count_nxt <= thresh_nxt);
  end

  assign o_irq = irq_r;

  // Output structure packing.
  always_comb begin
    o_apbo         = '0;
    o_apbo.pready  = pready_r;
    o_apbo.prdata  = prdata_r;
    o_apbo.pslverr = pslverr_r;
    o_cfg            = '0;
    o_cfg.vid        = VENDOR_OPTIMITECH;
    o_cfg.did        = did;
    o_cfg.addr_start = i_mapinfo.addr;
    o_cfg.addr_end   = i_mapinfo.addr | ~i_mapinfo.mask;
  end

endmodule

// File: tb/tb_accel_apb_cmdfifo.sv
// Directed bench for accel_apb_cmdfifo.
module tb_accel_apb_cmdfifo;
  import accel_apb_cmdfifo_pkg::*;

  logic           clk = 1'b0;
  logic           nrst;
  mapinfo_type    mapinfo;
  dev_config_type cfg;
  apb_in_type     apbi;
  apb_out_type    apbo;
  logic           cmd_valid;
  logic [31:0]    cmd_data;
  logic           cmd_ready;
  logic           irq;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [31:0] rdv;
  logic        errv;

  always #5 clk = ~clk;

  accel_apb_cmdfifo #(.fifo_log2(4)) dut (
    .i_clk       (clk),
    .i_nrst      (nrst),
    .i_mapinfo   (mapinfo),
    .o_cfg       (cfg),
    .i_apbi      (apbi),
    .o_apbo      (apbo),
    .o_cmd_valid (cmd_valid),
    .o_cmd_data  (cmd_data),
    .i_cmd_ready (cmd_ready),
    .o_irq       (irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One APB transfer; rdy is the stream ready level during the setup cycle.
  task automatic apb(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] strb, input logic rdy,
                     output logic [31:0] rdata, output logic err);
    @(negedge clk);
    apbi.pselx   = 1'b1;
    apbi.penable = 1'b0;
    apbi.paddr   = addr;
    apbi.pwrite  = wr;
    apbi.pwdata  = wdata;
    apbi.pstrb   = strb;
    apbi.pprot   = 3'd0;
    cmd_ready    = rdy;
    @(negedge clk);
    apbi.penable = 1'b1;
    cmd_ready    = 1'b0;
    check("pready_access", 32'(apbo.pready), 32'd1);
    rdata = apbo.prdata;
    err   = apbo.pslverr;
    @(negedge clk);
    apbi.pselx   = 1'b0;
    apbi.penable = 1'b0;
    apbi.pwrite  = 1'b0;
    check("pready_drop", 32'(apbo.pready), 32'd0);
  endtask

  task automatic pop_one();
    @(negedge clk);
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
  endtask

  initial begin
    nrst      = 1'b0;
    apbi      = '0;
    cmd_ready = 1'b0;
    mapinfo   = '{addr: 32'h0800_4000, mask: 32'hFFFF_F000};
    repeat (2) @(negedge clk);
    check("rst_pready", 32'(apbo.pready), 32'd0);
    check("rst_prdata", apbo.prdata, 32'd0);
    check("rst_pslverr", 32'(apbo.pslverr), 32'd0);
    check("rst_valid", 32'(cmd_valid), 32'd0);
    check("rst_data", cmd_data, 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("cfg_vid", 32'(cfg.vid), 32'h00F1);
    check("cfg_did", 32'(cfg.did), 32'h0092);
    check("cfg_end", cfg.addr_end, 32'h0800_4FFF);
    nrst = 1'b1;

    // Status after reset
    apb(1'b0, 32'h04, 32'd0, 4'h0, 1'b0, rdv, errv);
    check("st_reset", rdv, 32'h0000_0001);
    check("st_reset_err", 32'(errv), 32'd0);
    check("valid_idle", 32'(cmd_valid), 32'd0);

    // Single push and pop
    apb(1'b1, 32'h08, 32'h1, 4'hF, 1'b0, rdv, errv);
    apb(1'b1, 32'h00, 32'h1122_3344, 4'hF, 1'b0, rdv, errv);
    check("push1_valid", 32'(cmd_valid), 32'd1);
    check("push1_data", cmd_data, 32'h1122_3344);
    apb(1'b0, 32'h04, 32'd0, 4'h0, 1'b0, rdv, errv);
    check("st_one", rdv, 32'h0000_0100);
    pop_one();
    check("pop1_valid", 32'(cmd_valid), 32'd0);
    apb(1'b0, 32'h04, 32'd0, 4'h0, 1'b0, rdv, errv);
    check("st_popped", rdv, 32'h0000_0001);

    // Fill, overflow, drain
    apb(1'b1, 32'h08, 32'h0, 4'hF, 1'b0, rdv, errv);
    for (int i = 0; i < 16; i++) begin
      apb(1'b1, 32'h00, 32'(i), 4'hF, 1'b0, rdv, errv);
      check("fill_err", 32'(errv), 32'd0);
    end
    apb(1'b1, 32'h00, 32'h0000_DEAD, 4'hF, 1'b0, rdv, errv);
    check("ovf_err", 32'(errv), 32'd1);
    apb(1'b0, 32'h04, 32'd0, 4'h0, 1'b0, rdv, errv);
    check("st_full", rdv, 32'h0000_1006);
    check("valid_dis", 32'(cmd_valid), 32'd0);
    apb(1'b1, 32'h08, 32'h1, 4'hF, 1'b0, rdv, errv);
    for (int i = 0; i < 16; i++) begin
      check("stream_valid", 32'(cmd_valid), 32'd1);
      check("stream_data", cmd_data, 32'(i));
      cmd_ready = 1'b1;
      @(negedge clk);
    end
    cmd_ready = 1'b0;
    check("drained_valid", 32'(cmd_valid), 32'd0);
    apb(1'b0, 32'h04, 32'd0, 4'h0, 1'b0, rdv, errv);
    check("st_drained", rdv, 32'h0000_0005);
    apb(1'b1, 32'h08, 32'h9, 4'hF, 1'b0, rdv, errv);
    apb(1'b0, 32'h04, 32'd0, 4'h0, 1'b0, rdv, errv);
    check("st_ovf_clr", rdv, 32'h0000_0001);
    apb(1'b0, 32'h08, 32'd0, 4'h0, 1'b0, rdv, errv);
    check("ctrl_rd", rdv, 32'h0000_0001);

    // Byte strobes
    apb(1'b1, 32'h00, 32'hAABB_CCDD, 4'b0101, 1'b0, rdv, errv);
    check("strb_valid", 32'(cmd_valid), 32'd1);
    check("strb_data", cmd_data, 32'h00BB_00DD);
    pop_one();
    apb(1'b0, 32'h04, 32'd0, 4'h0, 1'b0, rdv, errv);
    check("st_strb", rdv, 32'h0000_0001);

    // Low-watermark interrupt
    apb(1'b1, 32'h0C, 32'hFFFF_FFE2, 4'hF, 1'b0, rdv, errv);
    apb(1'b0, 32'h0C, 32'd0, 4'h0, 1'b0, rdv, errv);
    check("thresh_rd", rdv, 32'h0000_0002);
    check("irq_off", 32'(irq), 32'd0);
    apb(1'b1, 32'h08, 32'h3, 4'hF, 1'b0, rdv, errv);
    check("irq_empty", 32'(irq), 32'd1);
    for (int i = 0; i < 4; i++) apb(1'b1, 32'h00, 32'hA0 + 32'(i), 4'hF, 1'b0, rdv, errv);
    check("irq_four", 32'(irq), 32'd0);
    apb(1'b0, 32'h04, 32'd0, 4'h0, 1'b0, rdv, errv);
    check("st_four", rdv, 32'h0000_0400);
    pop_one();
    check("irq_three", 32'(irq), 32'd0);
    pop_one();
    check("irq_two", 32'(irq), 32'd1);
    check("head_after2", cmd_data, 32'h0000_00A2);

    // Flush on the same edge as a pop
    apb(1'b1, 32'h00, 32'h0000_00A4, 4'hF, 1'b0, rdv, errv);
    apb(1'b1, 32'h08, 32'h5, 4'hF, 1'b1, rdv, errv);
    check("flush_valid", 32'(cmd_valid), 32'd0);
    check("flush_irq", 32'(irq), 32'd0);
    apb(1'b0, 32'h04, 32'd0, 4'h0, 1'b0, rdv, errv);
    check("st_flush", rdv, 32'h0000_0001);
    apb(1'b0, 32'h08, 32'd0, 4'h0, 1'b0, rdv, errv);
    check("ctrl_after_flush", rdv, 32'h0000_0001);
    apb(1'b1, 32'h00, 32'h0000_0077, 4'hF, 1'b0, rdv, errv);
    check("post_flush_data", cmd_data, 32'h0000_0077);
    apb(1'b0, 32'h04, 32'd0, 4'h0, 1'b0, rdv, errv);
    check("st_post_flush", rdv, 32'h0000_0100);

    // Decode errors and DATA read
    apb(1'b0, 32'h10, 32'd0, 4'h0, 1'b0, rdv, errv);
    check("bad_rd_data", rdv, 32'd0);
    check("bad_rd_err", 32'(errv), 32'd1);
    apb(1'b1, 32'h10, 32'h1234_5678, 4'hF, 1'b0, rdv, errv);
    check("bad_wr_err", 32'(errv), 32'd1);
    apb(1'b0, 32'h00, 32'd0, 4'h0, 1'b0, rdv, errv);
    check("data_rd", rdv, 32'd0);
    check("data_rd_err", 32'(errv), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/accel_apb_cmdfifo.md
Name: accel_apb_cmdfifo

Overview:
- APB slave on accelerator bus1, directly downstream of the bus1 AXI-to-APB bridge.
- Consumes one apb_in_type slot and returns apb_out_type.
- The CPU pushes 32-bit command words into an internal FIFO; the accelerator core drains them through a valid/ready stream.
- Provides status, control, flush and a low-watermark interrupt.

Parameters:
- fifo_log2, 4, log2 of FIFO depth (depth = 2**fifo_log2, 16 entries); count is fifo_log2+1 bits wide.
- did, OPTIMITECH_ACCEL_CMDFIFO, device ID reported in o_cfg (vid fixed to VENDOR_OPTIMITECH).

Ports:
- i_clk  in  1  single clock.
- i_nrst  in  1  reset, asynchronous, active-low.
- i_mapinfo  in  mapinfo_type  base-address info, only reflected into o_cfg.
- o_cfg  out  dev_config_type  PnP descriptor (vid, did, address range from i_mapinfo).
- i_apbi  in  apb_in_type  APB request from the bridge: pselx, penable, paddr, pwrite, pwdata[31:0], pstrb[3:0], pprot.
- o_apbo  out  apb_out_type  APB response: pready, prdata[31:0], pslverr.
- o_cmd_valid  out  1  command word available.
- o_cmd_data  out  32  FIFO head word.
- i_cmd_ready  in  1  consumer accepts the head word.
- o_irq  out  1  level interrupt, registered.

Behaviour:
- Clocking and reset: one clock. Asynchronous active-low reset clears all state.
- Reset values: pready=0, prdata=0, pslverr=0, o_cmd_valid=0, o_cmd_data=0, o_irq=0, count=0, wr_ptr=rd_ptr=0, CTRL=0, THRESH=0.
- Register map (decoded on paddr[11:2]):
  - 0x00 DATA. Write pushes pwdata; bytes whose pstrb bit is 0 are stored as 0x00. Read returns 0.
  - 0x04 STATUS, read-only. [0] empty, [1] full, [2] overflow sticky, [15:8] count (zero-extended). Write ignored, pslverr=0.
  - 0x08 CTRL. [0] stream enable, [1] irq enable, [2] flush (write-1 pulse, reads 0), [3] overflow clear (write-1 pulse, reads 0). Read returns {28'd0, 2'b00, irq_en, en}.
  - 0x0C THRESH. [fifo_log2:0] low-watermark, read/write; upper bits read 0.
  - Any other offset: read 0, write discarded, pslverr=1.
- APB timing: zero wait states, registered response.
  - Setup cycle (pselx=1, penable=0): on its closing edge the slave decodes, commits the write or samples the read data, and registers prdata/pslverr with pready=1.
  - Access cycle (pselx=1, penable=1): presents pready=1. The following edge clears pready to 0.
  - pready is never high outside an access cycle. prdata is held until the next setup commit.
  - Transfers are spaced by at least one idle cycle on this bus; back-to-back setup is not required.
- Push to a full FIFO: word dropped, pslverr=1, overflow sticky set, count unchanged. Fullness is judged on the count at the setup edge, even if a pop occurs on the same edge.
- Stream interface:
  - o_cmd_valid = en & ~empty; o_cmd_data = mem[rd_ptr]. Both are driven from registered state.
  - Pop on the edge where valid & ready: rd_ptr+1, wrapping modulo depth.
  - Clearing en while valid drops o_cmd_valid the next cycle; no word is lost.
- Simultaneous push and pop (not full): count unchanged, both pointers advance.
- Flush: rd_ptr=wr_ptr=0, count=0 on the commit edge. A pop on the same edge is ignored. The overflow sticky is not cleared.
- Pointers wrap modulo depth. Count is 0..depth inclusive.
- IRQ: o_irq registered = irq_en & en & (count <= THRESH), computed from the next-state count. Updates one cycle after the change.

Test Plan:
- Reset release, read STATUS at 0x04 -> prdata=0x00000001, pslverr=0, pready high exactly one cycle in access; o_cmd_valid=0.
- CTRL=0x1, ready held 0, write 0x11223344 to DATA, then read STATUS -> o_cmd_valid=1, o_cmd_data=0x11223344, STATUS=0x00000100; raise ready for one cycle -> one pop, STATUS=0x00000001.
- en=0, push 16 words 0..15, push 0xDEAD -> 17th access pslverr=1, STATUS=0x00001006; set en, ready=1 -> stream emits 0..15 in order, no 0xDEAD; write CTRL=0x9 -> overflow cleared.
- Write with pstrb=4'b0101, pwdata=0xAABBCCDD -> popped word 0x00BB00DD.
- THRESH=2, CTRL=0x3, push 4 words with ready=0 -> o_irq=0; pop 2 -> o_irq=1 one cycle after count reaches 2.
- 3 words queued, write CTRL=0x5 on the same edge as a pop -> count=0, o_cmd_valid=0 the next cycle; access to 0x10 -> pslverr=1, prdata=0.
